// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NrPorts requesters and registers the chosen result with port and trans_id tags.
// Latency: a grant in cycle N shows up as res_valid_o in cycle N+1; one operation per cycle while res_ready_i stays high.
// Backpressure: a full result register with res_ready_i low, or flush_i, zeroes every req_ready_o. Macro ALU_SHARE_ARB_RR_EN selects round-robin; undefined gives fixed priority.

package alu_share_arb_pkg;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned TRANS_ID_BITS;
    } cva6_cfg_t;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 3;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: XLEN, TRANS_ID_BITS: TRANS_ID_BITS};

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_EQ  = 4'd2,
        ALU_NE  = 4'd3
    } fu_op_t;

    typedef struct packed {
        fu_op_t                   operation;
        logic [XLEN-1:0]          operand_a;
        logic [XLEN-1:0]          operand_b;
        logic [XLEN-1:0]          imm;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;
endpackage

module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned NrPorts = 2,
    localparam int unsigned PortW  = $clog2(NrPorts)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic [NrPorts-1:0]               req_valid_i,
    output logic [NrPorts-1:0]               req_ready_o,
    input  fu_data_t [NrPorts-1:0]           req_data_i,
    output fu_data_t                         alu_data_o,
    input  logic [CVA6Cfg.XLEN-1:0]          alu_result_i,
    input  logic                             alu_branch_res_i,
    output logic                             res_valid_o,
    input  logic                             res_ready_i,
    output logic [CVA6Cfg.XLEN-1:0]          res_data_o,
    output logic                             res_branch_o,
    output logic [CVA6Cfg.TRANS_ID_BITS-1:0] res_trans_id_o,
    output logic [PortW-1:0]                 res_port_o
);

    logic                             r_vld;
    logic [CVA6Cfg.XLEN-1:0]          r_data;
    logic                             r_branch;
    logic [CVA6Cfg.TRANS_ID_BITS-1:0] r_tid;
    logic [PortW-1:0]                 r_port;

    logic                             w_can_accept;
    logic                             w_found;
    logic                             w_grant;
    logic [PortW-1:0]                 w_gnt_idx;
    logic [PortW-1:0]                 w_sel_idx;

    // A slot is free when empty or being drained this cycle; flush blocks all grants.
    assign w_can_accept = (!r_vld || res_ready_i) && !flush_i;
    assign w_grant      = w_can_accept && w_found;

`ifdef ALU_SHARE_ARB_RR_EN
    logic [PortW-1:0] r_rr;

    // Round-robin search: ports at or above the pointer first, then wrap to the low ports.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned p = 0; p < NrPorts; p++) begin
            if (!w_found && req_valid_i[PortW'(p)] && (PortW'(p) >= r_rr)) begin
                w_found   = 1'b1;
                w_gnt_idx = PortW'(p);
            end
        end
        for (int unsigned p = 0; p < NrPorts; p++) begin
            if (!w_found && req_valid_i[PortW'(p)]) begin
                w_found   = 1'b1;
                w_gnt_idx = PortW'(p);
            end
        end
    end

    // Idle ALU input follows the pointer port so the operand bus stays quiet.
    assign w_sel_idx = w_grant ? w_gnt_idx : r_rr;

    // Pointer advances past the winner only when a grant is actually made.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else if (w_grant) begin
            r_rr <= (w_gnt_idx == PortW'(NrPorts - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end
`else
    // Fixed priority: the lowest-index valid port wins.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned p = 0; p < NrPorts; p++) begin
            if (!w_found && req_valid_i[PortW'(p)]) begin
                w_found   = 1'b1;
                w_gnt_idx = PortW'(p);
            end
        end
    end

    assign w_sel_idx = w_grant ? w_gnt_idx : '0;
`endif

    assign alu_data_o = req_data_i[w_sel_idx];

    // One-hot accept toward the winning requester, all-zero otherwise.
    always_comb begin
        req_ready_o = '0;
        if (w_grant) begin
            req_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    // Result register: load on grant, otherwise drop valid on handoff or flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld    <= 1'b0;
            r_data   <= '0;
            r_branch <= 1'b0;
            r_tid    <= '0;
            r_port   <= '0;
        end else if (w_grant) begin
            r_vld    <= 1'b1;
            r_data   <= alu_result_i;
            r_branch <= alu_branch_res_i;
            r_tid    <= req_data_i[w_gnt_idx].trans_id;
            r_port   <= w_gnt_idx;
        end else if (res_ready_i || flush_i) begin
            r_vld    <= 1'b0;
        end
    end

    assign res_valid_o    = r_vld;
    assign res_data_o     = r_data;
    assign res_branch_o   = r_branch;
    assign res_trans_id_o = r_tid;
    assign res_port_o     = r_port;

endmodule
